// File: rtl/i2s_capture_ctrl.sv
// I2S sample capture: optionally decimates kept samples and writes each one to a byte FIFO, MSB first.
// Optional decimation is enabled by defining I2S_CAPTURE_DECIMATE_EN; the default build keeps every sample.
module i2s_capture_ctrl #(
   parameter int DATA_SIZE     = 24,
   parameter int FIFO_WIDTH    = 8,
   parameter int REDUCE_FACTOR = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_start,
   input  logic                  cmd_stop,
   input  logic [23:0]           cfg_len,
   input  logic                  sample_valid,
   input  logic [DATA_SIZE-1:0]  sample_data,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [FIFO_WIDTH-1:0] fifo_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [23:0]           sample_count
);

   localparam int BYTES = DATA_SIZE / FIFO_WIDTH;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      EMIT    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DATA_SIZE-1:0] shift_q;
   logic [BW-1:0]        byte_idx;
   logic [23:0]          len_q;
   logic [23:0]          count_inc;
   logic                 stop_pend;
   logic                 in_session;
   logic                 start_acc;
   logic                 kept;
   logic                 emit_step;
   logic                 last_byte;

   assign in_session = (state == CAPTURE) || (state == EMIT);
   assign start_acc  = cmd_start && ((state == IDLE) || (state == DONE));
   assign emit_step  = (state == EMIT) && !fifo_full;
   assign last_byte  = emit_step && (byte_idx == BW'(BYTES - 1));
   assign count_inc  = (sample_count == 24'hFFFFFF) ? sample_count : sample_count + 24'd1;

`ifdef I2S_CAPTURE_DECIMATE_EN
   localparam int DW = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;

   logic [DW-1:0] dec_cnt;

   // Counter phase 0 marks the sample to keep; it restarts with every session.
   assign kept = sample_valid && in_session && (dec_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         dec_cnt <= '0;
      end else if (sample_valid && in_session) begin
         if (dec_cnt == DW'(REDUCE_FACTOR - 1)) begin
            dec_cnt <= '0;
         end else begin
            dec_cnt <= dec_cnt + DW'(1);
         end
      end
   end
`else
   assign kept = sample_valid && in_session;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (cmd_start) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (cmd_stop) begin
               state_nxt = DONE;
            end else if (kept) begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            // A stop seen on the final byte counts the same as one already pending.
            if (last_byte) begin
               if (stop_pend || cmd_stop || ((len_q != 24'd0) && (count_inc == len_q))) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = CAPTURE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q      <= '0;
         byte_idx     <= '0;
         len_q        <= '0;
         stop_pend    <= 1'b0;
         overflow     <= 1'b0;
         sample_count <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         busy <= (state_nxt == CAPTURE) || (state_nxt == EMIT);
         done <= (state_nxt == DONE);

         if (start_acc) begin
            len_q        <= cfg_len;
            sample_count <= '0;
            overflow     <= 1'b0;
            stop_pend    <= 1'b0;
         end

         if ((state == CAPTURE) && kept && !cmd_stop) begin
            shift_q  <= sample_data;
            byte_idx <= '0;
         end

         if (state == EMIT) begin
            if (kept) begin
               overflow <= 1'b1;
            end
            if (cmd_stop && !last_byte) begin
               stop_pend <= 1'b1;
            end
            if (emit_step) begin
               shift_q <= shift_q << FIFO_WIDTH;
               if (last_byte) begin
                  byte_idx     <= '0;
                  sample_count <= count_inc;
                  stop_pend    <= 1'b0;
               end else begin
                  byte_idx <= byte_idx + BW'(1);
               end
            end
         end
      end
   end

   // Write strobe is the registered EMIT state gated by this cycle's full flag.
   assign fifo_wr_en   = (state == EMIT) && !fifo_full;
   assign fifo_wr_data = shift_q[DATA_SIZE-1 -: FIFO_WIDTH];

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_i2s_capture_ctrl;

   localparam int NB = 3;
`ifdef I2S_CAPTURE_DECIMATE_EN
   localparam int R = 2;
`else
   localparam int R = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_stop = 1'b0;
   logic [23:0] cfg_len = '0;
   logic        sample_valid = 1'b0;
   logic [23:0] sample_data = '0;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [23:0] sample_count;

   always #5 clk = ~clk;

   i2s_capture_ctrl dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .cfg_len(cfg_len), .sample_valid(sample_valid), .sample_data(sample_data),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .busy(busy), .done(done), .overflow(overflow), .sample_count(sample_count)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Reference model: session/finished flags plus a queue of bytes still owed to the FIFO.
   bit          m_sess, m_fin, m_stopf, m_ovf;
   int          m_phase;
   logic [23:0] m_cnt, m_len;
   logic [7:0]  m_q[$];
   logic [7:0]  exp_log[$];
   logic [7:0]  wr_log[$];
   int          wr_cyc[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit keep;
      if (rst) begin
         m_sess = 0; m_fin = 0; m_stopf = 0; m_ovf = 0; m_phase = 0; m_cnt = '0;
         m_q.delete();
         return;
      end
      if (!m_sess) begin
         if (cmd_start) begin
            m_sess = 1; m_fin = 0; m_len = cfg_len; m_cnt = '0;
            m_ovf = 0; m_stopf = 0; m_phase = 0;
         end
         return;
      end
      keep = sample_valid && (m_phase == 0);
      if (sample_valid) m_phase = (m_phase + 1) % R;
      if (m_q.size() == 0) begin
         if (cmd_stop) begin
            m_sess = 0; m_fin = 1;
         end else if (keep) begin
            for (int b = NB - 1; b >= 0; b--) m_q.push_back(sample_data[b*8 +: 8]);
         end
      end else begin
         if (keep) m_ovf = 1;
         if (cmd_stop) m_stopf = 1;
         if (!fifo_full) begin
            exp_log.push_back(m_q.pop_front());
            if (m_q.size() == 0) begin
               if (m_cnt != 24'hFFFFFF) m_cnt = m_cnt + 24'd1;
               if (m_stopf || (m_len != 0 && m_cnt == m_len)) begin
                  m_sess = 0; m_fin = 1;
               end
               m_stopf = 0;
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, advance the model on the rising edge, release pulses.
   task automatic step();
      bit exp_wr;
      @(negedge clk);
      if (fifo_wr_en === 1'b1) begin
         wr_log.push_back(fifo_wr_data);
         wr_cyc.push_back(cyc);
      end
      if (chk_en) begin
         exp_wr = (m_q.size() > 0) && !fifo_full;
         check("wr_while_full", {31'b0, fifo_wr_en & fifo_full}, 32'd0);
         check("wr_en", {31'b0, fifo_wr_en}, {31'b0, exp_wr});
         if (exp_wr) check("wr_data", {24'b0, fifo_wr_data}, {24'b0, m_q[0]});
         check("busy", {31'b0, busy}, {31'b0, m_sess});
         check("done", {31'b0, done}, {31'b0, m_fin});
         check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
         check("sample_count", {8'b0, sample_count}, {8'b0, m_cnt});
      end
      @(posedge clk);
      cyc++;
      model_update();
      #1;
      rst = 0; cmd_start = 0; cmd_stop = 0; sample_valid = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1; step();
      wr_log.delete(); wr_cyc.delete(); exp_log.delete();
   endtask

   task automatic start(input logic [23:0] len);
      cmd_start = 1; cfg_len = len; step();
   endtask

   task automatic sample(input logic [23:0] d);
      sample_valid = 1; sample_data = d; step();
   endtask

   initial begin
      // Reset and idle state
      do_reset();
      chk_en = 1;
      check("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      check("rst_wr_data", {24'b0, fifo_wr_data}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_count", {8'b0, sample_count}, 32'd0);
      idle(2);

      // Two samples, session length 2
      start(24'd2); idle(2);
      sample(24'hABCDEF); idle(9);
      sample(24'h123456); idle(10);
      check("len2_nbytes", wr_log.size(), exp_log.size());

      // Back-pressure for 5 cycles after the first byte
      do_reset();
      start(24'd0); idle(1);
      sample(24'h112233);
      idle(1);
      fifo_full = 1; idle(5);
      fifo_full = 0; idle(5);
      check("bp_nwrites", wr_log.size(), 32'd3);
      if (wr_log.size() == 3) begin
         check("bp_b0", {24'b0, wr_log[0]}, 32'h11);
         check("bp_b1", {24'b0, wr_log[1]}, 32'h22);
         check("bp_b2", {24'b0, wr_log[2]}, 32'h33);
         check("bp_gap", wr_cyc[1] - wr_cyc[0], 32'd6);
      end

      // Kept sample arriving during EMIT is dropped
      do_reset();
      start(24'd0); idle(1);
      sample(24'h0A0B0C);
      sample(24'h111111);
      sample(24'h222222);
      idle(5);
      check("ovf_set", {31'b0, overflow}, 32'd1);
      check("ovf_count", {8'b0, sample_count}, 32'd1);
      check("ovf_nbytes", wr_log.size(), 32'd3);
      cmd_stop = 1; step();
      start(24'd0);
      check("ovf_cleared", {31'b0, overflow}, 32'd0);

      // Stop during EMIT completes the sample; stop in CAPTURE finishes immediately
      do_reset();
      start(24'd0); idle(1);
      sample(24'h445566);
      step();
      cmd_stop = 1; step();
      idle(3);
      check("stop_emit_nbytes", wr_log.size(), 32'd3);
      check("stop_emit_done", {31'b0, done}, 32'd1);
      do_reset();
      start(24'd0); idle(2);
      cmd_stop = 1; step();
      check("stop_cap_done", {31'b0, done}, 32'd1);
      check("stop_cap_busy", {31'b0, busy}, 32'd0);
      check("stop_cap_nowrite", wr_log.size(), 32'd0);

      // Reset on the second byte aborts the sample
      do_reset();
      start(24'd0); idle(1);
      sample(24'h778899);
      step();
      rst = 1; step();
      check("rst_mid_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_data", {24'b0, fifo_wr_data}, 32'd0);
      idle(4);
      check("rst_mid_nwrites", wr_log.size(), 32'd2);

      // Randomised traffic
      do_reset();
      start(24'($urandom_range(0, 5)));
      for (int i = 0; i < 1500; i++) begin
         sample_valid = ($urandom_range(0, 5) == 0);
         sample_data  = 24'($urandom);
         fifo_full    = ($urandom_range(0, 3) == 0);
         cmd_stop     = ($urandom_range(0, 79) == 0);
         cmd_start    = ($urandom_range(0, 29) == 0);
         cfg_len      = 24'($urandom_range(0, 5));
         rst          = ($urandom_range(0, 399) == 0);
         step();
      end
      fifo_full = 0;
      idle(5);
      check("rand_nbytes", wr_log.size(), exp_log.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
